// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that merges NREQ byte streams into one TX FIFO feeding a uart_tx.
// Define UART_TX_SCHED_LINE_LOCK_EN to hold the grant on one requester until it sends 8'h0A.
module uart_tx_sched #(
  parameter int NREQ     = 4,
  parameter int DEPTH    = 16,
  parameter int LOCK_TMO = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_vld,
  input  logic [NREQ*8-1:0]         req_ch,
  output logic [NREQ-1:0]           req_rdy,
  output logic                      tx_vld,
  output logic [7:0]                tx_ch,
  input  logic                      tx_rdy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      owner_vld,
  output logic [$clog2(NREQ)-1:0]   owner
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(NREQ);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   rr_last, win;
  logic            win_vld, push, pop;
  logic [NREQ-1:0] mask, elig;
  logic [7:0]      push_ch;
  int              j;

  assign elig = req_vld & mask;

  // Walk from the farthest candidate back to the nearest so the nearest eligible
  // index after rr_last is the last one written.
  always_comb begin
    win     = rr_last;
    win_vld = 1'b0;
    j       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(rr_last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (elig[OW'(j)]) begin
        win     = OW'(j);
        win_vld = 1'b1;
      end
    end
  end

  // Full is judged on the registered level; a same-cycle pop does not open a slot.
  assign push    = win_vld && (level < FULL) && !rst;
  assign push_ch = req_ch[8*int'(win) +: 8];
  assign tx_vld  = (level != '0);
  assign tx_ch   = mem[rd_ptr];
  assign pop     = tx_vld && tx_rdy;

  always_comb begin
    req_rdy = '0;
    if (push) req_rdy[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rr_last <= OW'(NREQ-1);
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ch;
        wr_ptr      <= wr_ptr + 1'b1;
        rr_last     <= win;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

`ifdef UART_TX_SCHED_LINE_LOCK_EN
  localparam int TW = (LOCK_TMO < 1) ? 1 : $clog2(LOCK_TMO+1);
  logic [TW-1:0] tmo_cnt;

  always_comb begin
    mask = '1;
    if (owner_vld) begin
      mask        = '0;
      mask[owner] = 1'b1;
    end
  end

  // Timeout takes precedence; a lone newline never takes the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_vld <= 1'b0;
      owner     <= '0;
      tmo_cnt   <= '0;
    end else if (owner_vld) begin
      if (tmo_cnt == TW'(LOCK_TMO)) begin
        owner_vld <= 1'b0;
        tmo_cnt   <= '0;
      end else if (push) begin
        tmo_cnt <= '0;
        if (push_ch == 8'h0A) owner_vld <= 1'b0;
      end else if (!req_vld[owner]) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else if (push && push_ch != 8'h0A) begin
      owner_vld <= 1'b1;
      owner     <= win;
      tmo_cnt   <= '0;
    end
  end
`else
  assign mask      = '1;
  assign owner_vld = 1'b0;
  assign owner     = '0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a queue-based scheduling model.
module tb_uart_tx_sched;
  localparam int NREQ = 4, DEPTH = 16, LOCK_TMO = 255;
  localparam int LW = $clog2(DEPTH) + 1, OW = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_vld = '0;
  logic [NREQ*8-1:0] req_ch = '0;
  logic [NREQ-1:0]   req_rdy;
  logic              tx_vld;
  logic [7:0]        tx_ch;
  logic              tx_rdy = 1'b0;
  logic [LW-1:0]     level;
  logic              owner_vld;
  logic [OW-1:0]     owner;

  uart_tx_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .LOCK_TMO(LOCK_TMO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_ch(req_ch), .req_rdy(req_rdy),
    .tx_vld(tx_vld), .tx_ch(tx_ch), .tx_rdy(tx_rdy), .level(level),
    .owner_vld(owner_vld), .owner(owner));

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  logic [7:0] q [NREQ][$];
  logic [7:0] m_fifo [$];
  int rr = NREQ-1, ov = 0, ow = 0, idle = 0, fresh = 1;
  int rdy_pct = 100, refill_pct = 0;
  int gcnt [NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if ($urandom_range(3) == 0) b = 8'h0A;
    return b;
  endfunction

  function automatic bit busy();
    bit any;
    any = (m_fifo.size() != 0);
    for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) any = 1;
    return any;
  endfunction

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic r);
    int g, dg, di;
    logic [7:0] b;
    logic [NREQ-1:0] elig;
    bit pop;
    @(posedge clk); #1;
    rst = r;
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() < 4 && $urandom_range(99) < refill_pct) q[i].push_back(rand_byte());
      req_vld[i] = (q[i].size() != 0);
      req_ch[i*8 +: 8] = req_vld[i] ? q[i][0] : 8'h00;
    end
    tx_rdy = ($urandom_range(99) < rdy_pct);
    #1;
    elig = req_vld;
    if (ov != 0) elig = req_vld & (NREQ'(1) << ow);
    g = -1;
    if (!r && m_fifo.size() < DEPTH) begin
      // winner: smallest forward distance from the last accepted index
      for (int i = 0; i < NREQ; i++) if (elig[i]) begin
        di = (i - rr - 1 + 2*NREQ) % NREQ;
        dg = (g - rr - 1 + 2*NREQ) % NREQ;
        if (g < 0 || di < dg) g = i;
      end
    end
    chk("req_rdy", 32'(req_rdy), (g >= 0) ? (32'(1) << g) : 32'(0));
    chk("level", 32'(level), 32'(m_fifo.size()));
    chk("tx_vld", 32'(tx_vld), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("tx_ch", 32'(tx_ch), 32'(m_fifo[0]));
    else if (fresh != 0) chk("tx_ch_rst", 32'(tx_ch), 32'(0));
    chk("owner_vld", 32'(owner_vld), 32'(ov));
    chk("owner", 32'(owner), 32'(ow));
    for (int i = 0; i < NREQ; i++) if (req_rdy[i]) gcnt[i]++;

    pop = (m_fifo.size() != 0) && tx_rdy;
    if (r) begin
      m_fifo.delete();
      rr = NREQ-1; ov = 0; ow = 0; idle = 0; fresh = 1;
    end else begin
      b = 8'h00;
      if (pop) void'(m_fifo.pop_front());
      if (g >= 0) begin
        b = q[g].pop_front();
        m_fifo.push_back(b);
        rr = g;
        fresh = 0;
      end
`ifdef UART_TX_SCHED_LINE_LOCK_EN
      if (ov != 0) begin
        if (idle == LOCK_TMO) begin ov = 0; idle = 0; end
        else if (g >= 0) begin idle = 0; if (b == 8'h0A) ov = 0; end
        else if (!req_vld[ow]) idle++;
      end else if (g >= 0 && b != 8'h0A) begin
        ov = 1; ow = g; idle = 0;
      end
`endif
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    refill_pct = 0;
    rdy_pct = 100;
    while (busy() && n < 3000) begin step(0); n++; end
    chk("drain_bound", 32'(busy()), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    step(1);
    step(1);

    // single requester, "ABC"
    q[0].push_back(8'h41); q[0].push_back(8'h42); q[0].push_back(8'h43);
    drain();
    step(0);
    chk("abc_level", 32'(level), 32'(0));

`ifndef UART_TX_SCHED_LINE_LOCK_EN
    // fairness with every requester continuously valid
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    refill_pct = 100; rdy_pct = 100;
    for (int n = 0; n < 10*NREQ; n++) step(0);
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair%0d", i), 32'(gcnt[i]), 32'(10));
    drain();
`endif

    // full FIFO: 17th byte waits until a slot was freed on an earlier cycle
    rdy_pct = 0;
    for (int n = 0; n <= DEPTH; n++) q[0].push_back(8'($urandom));
    for (int n = 0; n <= DEPTH; n++) step(0);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_rdy", 32'(req_rdy), 32'(0));
    rdy_pct = 100; step(0);
    chk("full_pop_rdy", 32'(req_rdy), 32'(0));
    rdy_pct = 0; step(0);
    chk("full_late_rdy", 32'(req_rdy), 32'(1));
    drain();

    // push and pop together at level 5
    rdy_pct = 0;
    for (int n = 0; n < 5; n++) q[1].push_back(8'($urandom));
    for (int n = 0; n < 6; n++) step(0);
    for (int n = 0; n < 8; n++) q[1].push_back(8'($urandom));
    rdy_pct = 100;
    for (int n = 0; n < 6; n++) step(0);
    chk("pp_level", 32'(level), 32'(5));
    drain();

    // line text with a competing requester, then an idle owner
    q[1].push_back(8'h68); q[1].push_back(8'h69); q[1].push_back(8'h0A);
    for (int n = 0; n < 6; n++) q[2].push_back(8'($urandom_range(8'h20, 8'h7E)));
    drain();
    q[3].push_back(8'h78);
    for (int n = 0; n < 3; n++) step(0);
    q[2].push_back(8'h79);
    for (int n = 0; n < LOCK_TMO + 20; n++) step(0);
    drain();

    // randomized traffic
    for (int c = 0; c < 20; c++) begin
      rdy_pct = $urandom_range(20, 100);
      refill_pct = $urandom_range(10, 100);
      for (int n = 0; n < 100; n++) step(0);
    end
    drain();

    // reset mid-stream at level 7
    rdy_pct = 0;
    for (int n = 0; n < 7; n++) q[0].push_back(8'($urandom));
    for (int n = 0; n < 8; n++) step(0);
    chk("pre_rst_level", 32'(level), 32'(7));
    for (int i = 0; i < NREQ; i++) q[i].push_back(8'($urandom_range(8'h20, 8'h7E)));
    step(1);
    step(0);
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_tx_vld", 32'(tx_vld), 32'(0));
    chk("rst_owner_vld", 32'(owner_vld), 32'(0));
    chk("rst_first_win", 32'(req_rdy), 32'(1));
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
